fir_tdm_ctrl: RTL

- Time-multiplexed FIR controller: N_CH input channels share one multiply-accumulate unit.
- Holds a per-channel N-tap delay line and a runtime-programmable coefficient bank.
- Grants channels round-robin, then sequences the MAC over N taps, one tap per cycle.
- Presents each result on a valid/ready output tagged with its channel id.
- Sits between sample sources (ADC/channelizer) and downstream consumers; replaces N_CH parallel fixed-coefficient FIR instances.

---
 rtl/fir_tdm_ctrl_pkg.sv | 39 +++
 rtl/fir_tdm_ctrl_if.sv | 48 ++++
 rtl/fir_tdm_ctrl_rr_arbiter.sv | 47 ++++
 rtl/fir_tdm_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fir_tdm_ctrl_pkg.sv
// Shared types and helpers for the time-multiplexed FIR controller.
// Holds the FSM state type, coefficient reset values, width helpers and
// the output saturation function.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Coefficient bank comes out of reset as 1, 2, 3, ... so an impulse
    // produces a recognisable ramp.
    function automatic int default_coef(input int i);
        return i + 1;
    endfunction

    // Accumulator wide enough to sum n full-scale products without overflow.
    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + $clog2(n);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clip a signed value into the range of a dw-bit signed result.
    function automatic longint sat_val(input longint v, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_tdm_ctrl_if.sv
// Sample, result and coefficient buses of the TDM FIR controller.
// slave = the filter, master = the sources/consumers driving it.
// FIR_SAT_EN adds the sat_flag result qualifier.
interface fir_tdm_ctrl_if #(
    parameter int N           = 4,
    parameter int N_CH        = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16
);
    import fir_pkg::*;

    localparam int CH_W = idx_width(N_CH);
    localparam int AW   = idx_width(N);

    logic [N_CH*DATA_WIDTH-1:0]   in_data;
    logic [N_CH-1:0]              in_valid;
    logic [N_CH-1:0]              in_ready;
    logic [DATA_WIDTH-1:0]        y_data;
    logic [CH_W-1:0]              y_ch;
    logic                         y_valid;
    logic                         y_ready;
    logic                         coef_we;
    logic [AW-1:0]                coef_addr;
    logic signed [COEFF_WIDTH-1:0] coef_data;
    logic                         coef_ready;
`ifdef FIR_SAT_EN
    logic                         sat_flag;

    modport slave (
        input  in_data, in_valid, y_ready, coef_we, coef_addr, coef_data,
        output in_ready, y_data, y_ch, y_valid, coef_ready, sat_flag
    );
    modport master (
        output in_data, in_valid, y_ready, coef_we, coef_addr, coef_data,
        input  in_ready, y_data, y_ch, y_valid, coef_ready, sat_flag
    );
`else
    modport slave (
        input  in_data, in_valid, y_ready, coef_we, coef_addr, coef_data,
        output in_ready, y_data, y_ch, y_valid, coef_ready
    );
    modport master (
        output in_data, in_valid, y_ready, coef_we, coef_addr, coef_data,
        input  in_ready, y_data, y_ch, y_valid, coef_ready
    );
`endif

endinterface

// File: rtl/fir_tdm_ctrl_rr_arbiter.sv
// Round-robin arbiter for shared datapaths: one-hot grant to the first
// requester at or after the pointer; pointer moves past the winner on accept.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             en_i,
    input  logic             accept_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    gnt_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    // Scan requesters starting at the pointer, first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (en_i && !found && req_i[(int'(ptr_q) + i) % N_REQ]) begin
                found                                   = 1'b1;
                gnt_o[(int'(ptr_q) + i) % N_REQ]        = 1'b1;
                gnt_idx_o = IW'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    // Next pointer: one past the accepted requester, wrapping.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (int'(gnt_idx_o) == N_REQ - 1) ? '0 : gnt_idx_o + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fir_tdm_ctrl.sv
// Time-multiplexed FIR: N_CH channels share one MAC. A granted sample is
// shifted into its channel's delay line, then N taps are accumulated one per
// cycle and the result is held on y_* until accepted.
// Optional FIR_SAT_EN: saturate y_data and raise sat_flag on clipping.
module fir_tdm_ctrl
    import fir_pkg::*;
#(
    parameter int N           = 4,
    parameter int N_CH        = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    fir_tdm_ctrl_if.slave   bus,
    output logic            busy
);

    localparam int CH_W   = idx_width(N_CH);
    localparam int AW     = idx_width(N);
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH, N);
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

    state_e                         state_q, state_d;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic [AW-1:0]                  tap_q, tap_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]   dl_q [N_CH][N];
    logic signed [COEFF_WIDTH-1:0]  h_q  [N];

    logic                           idle;
    logic                           coef_wr;
    logic                           arb_en;
    logic                           hs;
    logic [N_CH-1:0]                gnt;
    logic [CH_W-1:0]                gnt_idx;
    logic signed [DATA_WIDTH-1:0]   sample;
    logic signed [PROD_W-1:0]       prod;

    // Reset holds the handshake outputs low even though state is IDLE.
    assign idle    = (state_q == IDLE) && !rst;
    assign coef_wr = idle && bus.coef_we;
    assign arb_en  = idle && !bus.coef_we;   // coefficient writes win over grants

    rr_arbiter #(.N_REQ(N_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.in_valid),
        .en_i      (arb_en),
        .accept_i  (hs),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Grant is only ever given to a valid requester, so any grant is a handshake.
    assign hs             = |gnt;
    assign bus.in_ready   = gnt;
    assign bus.coef_ready = idle;
    assign sample         = bus.in_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign prod           = dl_q[ch_q][tap_q] * h_q[tap_q];

    // FSM and MAC sequencing.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (hs) begin
                state_d = MAC;
                ch_d    = gnt_idx;
                tap_d   = '0;
                acc_d   = '0;
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (int'(tap_q) == N - 1) state_d = OUT;
                else                      tap_d   = tap_q + AW'(1);
            end
            OUT: if (bus.y_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
        end
    end

    // Per-channel delay lines; only the granted channel shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++)
                for (int k = 0; k < N; k++)
                    dl_q[c][k] <= '0;
        end else if (hs) begin
            for (int c = 0; c < N_CH; c++) begin
                if (gnt[c]) begin
                    dl_q[c][0] <= sample;
                    for (int k = N - 1; k > 0; k--)
                        dl_q[c][k] <= dl_q[c][k-1];
                end
            end
        end
    end

    // Coefficient bank; out-of-range addresses are acknowledged but dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                h_q[i] <= COEFF_WIDTH'(default_coef(i));
        end else if (coef_wr && int'(bus.coef_addr) < N) begin
            h_q[bus.coef_addr] <= bus.coef_data;
        end
    end

    assign bus.y_valid = (state_q == OUT);
    assign bus.y_ch    = ch_q;
    assign busy        = (state_q != IDLE);

`ifdef FIR_SAT_EN
    longint acc_l;
    longint acc_sat;
    assign acc_l        = longint'(acc_q);
    assign acc_sat      = sat_val(acc_l, DATA_WIDTH);
    assign bus.y_data   = acc_sat[DATA_WIDTH-1:0];
    assign bus.sat_flag = bus.y_valid && (acc_sat != acc_l);
`else
    // Plain truncation: wraps silently on overflow.
    assign bus.y_data   = acc_q[DATA_WIDTH-1:0];
`endif

endmodule
